// File: rtl/aes_pkg.sv
// Shared types, S-box tables and lookup helpers for the AES S-box server.
package aes_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } srv_state_t;

    localparam int LANES = 4;

    // Forward S-box, entry 0 in the most significant byte so SBOX[b] reads naturally.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Inverse S-box, same layout as SBOX.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox_lookup(input logic [7:0] b, input logic inv);
        return inv ? INV_SBOX[b] : SBOX[b];
    endfunction

    function automatic word_t sub_word(input word_t w, input logic inv);
        word_t r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = sbox_lookup(w[8*i +: 8], inv);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One byte lane of the shared S-box: selects the key or datapath byte and looks it up.
module aes_sbox_lane
    import aes_pkg::*;
#(
    parameter bit ENABLE_INV = 1'b1
) (
    input  logic       key_sel,
    input  logic [7:0] key_byte,
    input  logic [7:0] dp_byte,
    input  logic       dp_inv,
    output logic [7:0] sub_byte
);

    logic [7:0] lane_byte;

    // Key expansion owns the lane whenever it is active.
    always_comb begin
        lane_byte = key_sel ? key_byte : dp_byte;
    end

    generate
        if (ENABLE_INV) begin : g_inv
            logic use_inv;
            // Key schedule always uses the forward table.
            always_comb begin
                use_inv  = dp_inv & ~key_sel;
                sub_byte = sbox_lookup(lane_byte, use_inv);
            end
        end else begin : g_fwd
            logic unused_inv;
            assign unused_inv = dp_inv;
            // Forward-only build: the inverse request is ignored.
            always_comb begin
                sub_byte = SBOX[lane_byte];
            end
        end
    endgenerate

endmodule

// File: rtl/aes_sbox_server.sv
// Shared S-box responder: four byte lanes time-shared between the key schedule
// (strict priority, never stalled) and a word-serial 128-bit datapath request.
module aes_sbox_server
    import aes_pkg::*;
#(
    parameter bit ENABLE_INV = 1'b1,
    parameter int KEY_OUT_W  = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 key_req,
    input  logic [31:0]          key_word_in,
    output logic [KEY_OUT_W-1:0] key_sbox_out,
    input  logic                 dp_in_valid,
    output logic                 dp_in_ready,
    input  logic [127:0]         dp_in_data,
    input  logic                 dp_inv,
    output logic                 dp_out_valid,
    input  logic                 dp_out_ready,
    output logic [127:0]         dp_out_data,
    output logic                 busy
);

    srv_state_t           state_reg, state_next;
    logic [1:0]           idx_reg, idx_next;
    logic [127:0]         data_reg;
    logic                 inv_reg;
    logic [127:0]         result_reg;
    logic [KEY_OUT_W-1:0] key_out_reg;
    word_t                dp_word;
    word_t                lane_word;
    logic                 accept;
    logic                 sub_step;

    // Word idx of the latched state; word 0 sits in the top 32 bits.
    always_comb begin
        case (idx_reg)
            2'd0:    dp_word = data_reg[127:96];
            2'd1:    dp_word = data_reg[95:64];
            2'd2:    dp_word = data_reg[63:32];
            default: dp_word = data_reg[31:0];
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            aes_sbox_lane #(
                .ENABLE_INV(ENABLE_INV)
            ) u_lane (
                .key_sel  (key_req),
                .key_byte (key_word_in[8*gi +: 8]),
                .dp_byte  (dp_word[8*gi +: 8]),
                .dp_inv   (inv_reg),
                .sub_byte (lane_word[8*gi +: 8])
            );
        end
    endgenerate

    // Next-state and handshake decode; key_req freezes progress in SUB.
    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        dp_in_ready  = 1'b0;
        dp_out_valid = 1'b0;
        busy         = 1'b0;
        accept       = 1'b0;
        sub_step     = 1'b0;
        case (state_reg)
            IDLE: begin
                dp_in_ready = 1'b1;
                if (dp_in_valid) begin
                    accept     = 1'b1;
                    idx_next   = 2'd0;
                    state_next = SUB;
                end
            end
            SUB: begin
                busy = 1'b1;
                if (!key_req) begin
                    sub_step = 1'b1;
                    idx_next = idx_reg + 2'd1;
                    if (idx_reg == 2'd3) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                busy         = 1'b1;
                dp_out_valid = 1'b1;
                if (dp_out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state and word counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            idx_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // Request capture at accept; inverse flag forced low when inverse tables are absent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg <= '0;
            inv_reg  <= 1'b0;
        end else if (accept) begin
            data_reg <= dp_in_data;
            inv_reg  <= dp_inv & ENABLE_INV;
        end
    end

    // Result assembly, one word per non-stalled SUB cycle; held through DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_reg <= '0;
        end else if (sub_step) begin
            case (idx_reg)
                2'd0:    result_reg[127:96] <= lane_word;
                2'd1:    result_reg[95:64]  <= lane_word;
                2'd2:    result_reg[63:32]  <= lane_word;
                default: result_reg[31:0]   <= lane_word;
            endcase
        end
    end

    // Key-port SubWord register, zero-extended; holds while key_req is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_out_reg <= '0;
        end else if (key_req) begin
            key_out_reg <= KEY_OUT_W'(lane_word);
        end
    end

    assign key_sbox_out = key_out_reg;
    assign dp_out_data  = result_reg;

endmodule

// File: tb/tb_aes_sbox_server.sv
// Directed bench for aes_sbox_server: key port, forward/inverse datapath,
// key-priority stalls, output backpressure and asynchronous reset.
module tb_aes_sbox_server;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_req;
    logic [31:0]  key_word_in;
    logic [127:0] key_sbox_out;
    logic         dp_in_valid;
    logic         dp_in_ready;
    logic [127:0] dp_in_data;
    logic         dp_inv;
    logic         dp_out_valid;
    logic         dp_out_ready;
    logic [127:0] dp_out_data;
    logic         busy;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] PLAIN = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] SUBBD = 128'h638293c3_1bfc33f5_c4eeacea_4bc12816;

    aes_sbox_server #(
        .ENABLE_INV(1'b1),
        .KEY_OUT_W (128)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_req      (key_req),
        .key_word_in  (key_word_in),
        .key_sbox_out (key_sbox_out),
        .dp_in_valid  (dp_in_valid),
        .dp_in_ready  (dp_in_ready),
        .dp_in_data   (dp_in_data),
        .dp_inv       (dp_inv),
        .dp_out_valid (dp_out_valid),
        .dp_out_ready (dp_out_ready),
        .dp_out_data  (dp_out_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({dp_in_ready, busy, dp_out_valid} !== 3'b100) begin
            bad++;
            $display("FAIL reset_flags got=%b want=100", {dp_in_ready, busy, dp_out_valid});
        end
        total++;
        if (key_sbox_out !== 128'h0) begin
            bad++;
            $display("FAIL reset_key got=%h want=0", key_sbox_out);
        end
        total++;
        if (dp_out_data !== 128'h0) begin
            bad++;
            $display("FAIL reset_data got=%h want=0", dp_out_data);
        end
        $display("test_reset: ready=%b busy=%b valid=%b", dp_in_ready, busy, dp_out_valid);
    endtask

    task automatic test_key_port();
        key_req = 1'b1;
        key_word_in = 32'hcf4f3c09;
        @(negedge clk);
        total++;
        if (key_sbox_out !== {96'h0, 32'h8a84eb01}) begin
            bad++;
            $display("FAIL key_rotword got=%h want=8a84eb01", key_sbox_out);
        end
        $display("test_key_port: in=cf4f3c09 out=%h", key_sbox_out);
        key_word_in = 32'h00112233;
        @(negedge clk);
        total++;
        if (key_sbox_out !== {96'h0, 32'h638293c3}) begin
            bad++;
            $display("FAIL key_second got=%h want=638293c3", key_sbox_out);
        end
        $display("test_key_port: in=00112233 out=%h", key_sbox_out);
        key_req = 1'b0;
        key_word_in = 32'hffffffff;
        @(negedge clk);
        total++;
        if (key_sbox_out !== {96'h0, 32'h638293c3}) begin
            bad++;
            $display("FAIL key_hold got=%h want=638293c3", key_sbox_out);
        end
        $display("test_key_port: key_req=0 hold out=%h", key_sbox_out);
    endtask

    task automatic test_forward();
        int cyc;
        dp_in_valid = 1'b1;
        dp_in_data  = PLAIN;
        dp_inv      = 1'b0;
        @(negedge clk);
        dp_in_valid = 1'b0;
        dp_in_data  = '0;
        total++;
        if ({dp_in_ready, busy} !== 2'b01) begin
            bad++;
            $display("FAIL fwd_accept got=%b want=01", {dp_in_ready, busy});
        end
        cyc = 0;
        while (!dp_out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc !== 4) begin
            bad++;
            $display("FAIL fwd_latency got=%0d want=4", cyc);
        end
        total++;
        if (dp_out_data !== SUBBD) begin
            bad++;
            $display("FAIL fwd_data got=%h want=%h", dp_out_data, SUBBD);
        end
        $display("test_forward: latency=%0d data=%h", cyc, dp_out_data);
        dp_out_ready = 1'b1;
        @(negedge clk);
        dp_out_ready = 1'b0;
        total++;
        if ({dp_out_valid, dp_in_ready, busy} !== 3'b010) begin
            bad++;
            $display("FAIL fwd_release got=%b want=010", {dp_out_valid, dp_in_ready, busy});
        end
    endtask

    task automatic test_inverse_stall();
        logic [31:0] kw [0:3];
        logic [31:0] ks [0:3];
        int cyc;
        kw[0] = 32'h0;        ks[0] = 32'h0;
        kw[1] = 32'hcf4f3c09; ks[1] = 32'h8a84eb01;
        kw[2] = 32'h00112233; ks[2] = 32'h638293c3;
        kw[3] = 32'h44556677; ks[3] = 32'h1bfc33f5;
        dp_in_valid = 1'b1;
        dp_in_data  = SUBBD;
        dp_inv      = 1'b1;
        @(negedge clk);
        dp_in_valid = 1'b0;
        dp_inv      = 1'b0;
        cyc = 0;
        for (int c = 0; c < 20 && !dp_out_valid; c++) begin
            key_req     = (c >= 1 && c <= 3);
            key_word_in = kw[(c >= 1 && c <= 3) ? c : 0];
            @(negedge clk);
            cyc++;
            if (key_req) begin
                total++;
                if (key_sbox_out !== {96'h0, ks[c]}) begin
                    bad++;
                    $display("FAIL stall_key%0d got=%h want=%h", c, key_sbox_out, ks[c]);
                end
            end
        end
        key_req = 1'b0;
        total++;
        if (cyc !== 7) begin
            bad++;
            $display("FAIL inv_latency got=%0d want=7", cyc);
        end
        total++;
        if (dp_out_data !== PLAIN) begin
            bad++;
            $display("FAIL inv_data got=%h want=%h", dp_out_data, PLAIN);
        end
        $display("test_inverse_stall: latency=%0d data=%h key=%h", cyc, dp_out_data, key_sbox_out);
        dp_out_ready = 1'b1;
        @(negedge clk);
        dp_out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int cyc;
        dp_in_valid = 1'b1;
        dp_in_data  = PLAIN;
        dp_inv      = 1'b0;
        @(negedge clk);
        dp_in_data = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
        cyc = 0;
        while (!dp_out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc !== 4) begin
            bad++;
            $display("FAIL bp_latency got=%0d want=4", cyc);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({dp_out_valid, dp_in_ready} !== 2'b10 || dp_out_data !== SUBBD) begin
                bad++;
                $display("FAIL bp_hold%0d flags=%b data=%h want flags=10 data=%h",
                         i, {dp_out_valid, dp_in_ready}, dp_out_data, SUBBD);
            end
        end
        dp_out_ready = 1'b1;
        @(negedge clk);
        dp_out_ready = 1'b0;
        dp_in_valid  = 1'b0;
        total++;
        if ({dp_out_valid, dp_in_ready, busy} !== 3'b010) begin
            bad++;
            $display("FAIL bp_release got=%b want=010", {dp_out_valid, dp_in_ready, busy});
        end
        $display("test_backpressure: held 5 cycles data=%h", SUBBD);
    endtask

    task automatic test_reset_mid();
        key_req = 1'b1;
        key_word_in = 32'h44556677;
        @(negedge clk);
        key_req = 1'b0;
        dp_in_valid = 1'b1;
        dp_in_data  = PLAIN;
        @(negedge clk);
        dp_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_busy got=%b want=1", busy);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({dp_in_ready, busy, dp_out_valid} !== 3'b100 || key_sbox_out !== 128'h0
            || dp_out_data !== 128'h0) begin
            bad++;
            $display("FAIL mid_async flags=%b key=%h data=%h want flags=100 zeros",
                     {dp_in_ready, busy, dp_out_valid}, key_sbox_out, dp_out_data);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if ({dp_in_ready, busy, dp_out_valid} !== 3'b100) begin
                bad++;
                $display("FAIL mid_after%0d got=%b want=100", i, {dp_in_ready, busy, dp_out_valid});
            end
        end
        $display("test_reset_mid: dropped transaction ready=%b valid=%b", dp_in_ready, dp_out_valid);
    endtask

    initial begin
        reset        = 1'b1;
        key_req      = 1'b0;
        key_word_in  = '0;
        dp_in_valid  = 1'b0;
        dp_in_data   = '0;
        dp_inv       = 1'b0;
        dp_out_ready = 1'b0;
        test_reset();
        test_key_port();
        test_forward();
        test_inverse_stall();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
